// File: rtl/calc1_pkg.sv
// calc1 shared definitions: command codes, response codes, driver state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_OK    = 2'd1;
    localparam logic [1:0] RESP_OVFL  = 2'd2;
    localparam logic [1:0] RESP_INVAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND2 = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_req_driver.sv
// Requester agent for one calc1 port: takes cmd+2 operands, issues them over two
// request cycles, captures the single response (or a timeout) and holds it upstream.
// Latency: accept at edge N -> cmd/data1 on pins N+1, data2 N+2; result 1 cycle after response.
// Backpressure: op_rdy only in IDLE (one outstanding op); result held until res_rdy.
//
// Ports: c_clk/reset (async, active-low); op_* upstream operation handshake;
// req_cmd_out/req_data_out to calc1 request pins; resp_in/resp_data_in from calc1;
// res_* captured result handshake; spurious_err sticky unexpected-response flag.
module calc1_req_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 10
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_vld,
    output logic        op_rdy,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_data1,
    input  logic [0:31] op_data2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    input  logic [0:1]  resp_in,
    input  logic [0:31] resp_data_in,
    output logic        res_vld,
    input  logic        res_rdy,
    output logic [0:1]  res_resp,
    output logic [0:31] res_data,
    output logic        res_timeout,
    output logic        spurious_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        op2_q, op2_d;
    logic [3:0]         req_cmd_q, req_cmd_d;
    logic [31:0]        req_data_q, req_data_d;
    logic               res_vld_q, res_vld_d;
    logic [1:0]         res_resp_q, res_resp_d;
    logic [31:0]        res_data_q, res_data_d;
    logic               res_timeout_q, res_timeout_d;
    logic               spur_q, spur_d;
    logic               resp_seen;

    assign resp_seen = (resp_in != RESP_NONE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op2_d         = op2_q;
        // Request pins idle at zero unless this cycle drives a beat.
        req_cmd_d     = CMD_NOP;
        req_data_d    = '0;
        res_vld_d     = res_vld_q;
        res_resp_d    = res_resp_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        // Any response outside WAIT is unexpected (including one arriving after a
        // timeout); it is only flagged, never captured.
        spur_d        = spur_q | (resp_seen & (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (op_vld) begin
                    req_cmd_d  = op_cmd;
                    req_data_d = op_data1;
                    op2_d      = op_data2;
                    state_d    = SEND2;
                end
            end
            SEND2: begin
                req_data_d = op2_q;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A response on the limit cycle takes priority over the timeout.
                if (resp_seen) begin
                    res_resp_d    = resp_in;
                    res_data_d    = resp_data_in;
                    res_timeout_d = 1'b0;
                    res_vld_d     = 1'b1;
                    state_d       = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    res_resp_d    = RESP_NONE;
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    res_vld_d     = 1'b1;
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (res_rdy) begin
                    res_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op2_q         <= '0;
            req_cmd_q     <= CMD_NOP;
            req_data_q    <= '0;
            res_vld_q     <= 1'b0;
            res_resp_q    <= RESP_NONE;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            spur_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op2_q         <= op2_d;
            req_cmd_q     <= req_cmd_d;
            req_data_q    <= req_data_d;
            res_vld_q     <= res_vld_d;
            res_resp_q    <= res_resp_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            spur_q        <= spur_d;
        end
    end

    assign op_rdy       = (state_q == IDLE);
    assign req_cmd_out  = req_cmd_q;
    assign req_data_out = req_data_q;
    assign res_vld      = res_vld_q;
    assign res_resp     = res_resp_q;
    assign res_data     = res_data_q;
    assign res_timeout  = res_timeout_q;
    assign spurious_err = spur_q;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: directed operations, transaction-level reference model.
// Latency: n/a.
// Backpressure: exercised via res_rdy held low and tied high.
module tb_calc1_req_driver;
    import calc1_pkg::*;

    localparam int TMO = 4;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        op_vld;
    logic        op_rdy;
    logic [0:3]  op_cmd;
    logic [0:31] op_data1;
    logic [0:31] op_data2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  resp_in;
    logic [0:31] resp_data_in;
    logic        res_vld;
    logic        res_rdy;
    logic [0:1]  res_resp;
    logic [0:31] res_data;
    logic        res_timeout;
    logic        spurious_err;

    calc1_req_driver #(.TIMEOUT_CYCLES(TMO), .CNT_W(10)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_vld(op_vld), .op_rdy(op_rdy), .op_cmd(op_cmd),
        .op_data1(op_data1), .op_data2(op_data2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .resp_in(resp_in), .resp_data_in(resp_data_in),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_resp(res_resp),
        .res_data(res_data), .res_timeout(res_timeout),
        .spurious_err(spurious_err)
    );

    always #5 c_clk = ~c_clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding operation; m_k counts cycles since acceptance
    // (1 = first request beat). Response window opens with the second beat.
    bit        m_busy = 1'b0;
    bit        m_have = 1'b0;
    int        m_k    = 0;
    bit [3:0]  m_cmd  = '0;
    bit [31:0] m_d1   = '0;
    bit [31:0] m_d2   = '0;
    bit [1:0]  m_resp = '0;
    bit [31:0] m_data = '0;
    bit        m_to   = 1'b0;
    bit        m_spur = 1'b0;
    bit        m_win  = 1'b0;

    always @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_have = 0; m_k = 0; m_cmd = 0; m_d1 = 0; m_d2 = 0;
            m_resp = 0; m_data = 0; m_to = 0; m_spur = 0;
        end else begin
            m_win = m_busy && !m_have && (m_k >= 2);
            if (resp_in != 2'd0 && !m_win) m_spur = 1;
            if (!m_busy) begin
                if (op_vld) begin
                    m_busy = 1; m_k = 1;
                    m_cmd = op_cmd; m_d1 = op_data1; m_d2 = op_data2;
                end
            end else if (!m_have) begin
                if (m_k >= 2) begin
                    if (resp_in != 2'd0) begin
                        m_have = 1; m_resp = resp_in; m_data = resp_data_in; m_to = 0;
                    end else if (m_k - 1 == TMO) begin
                        m_have = 1; m_resp = 0; m_data = 0; m_to = 1;
                    end
                end
                m_k++;
            end else if (res_rdy) begin
                m_busy = 0; m_have = 0;
            end
        end
    end

    always @(negedge c_clk) begin
        if (cmp_en) begin
            chk("cyc_op_rdy", 32'(op_rdy), 32'(!m_busy));
            chk("cyc_req_cmd", 32'(req_cmd_out),
                (m_busy && !m_have && m_k == 1) ? 32'(m_cmd) : 32'd0);
            chk("cyc_req_data", req_data_out,
                (m_busy && !m_have && m_k == 1) ? m_d1 :
                (m_busy && !m_have && m_k == 2) ? m_d2 : 32'd0);
            chk("cyc_res_vld", 32'(res_vld), 32'(m_have));
            chk("cyc_res_resp", 32'(res_resp), 32'(m_resp));
            chk("cyc_res_data", res_data, m_data);
            chk("cyc_res_timeout", 32'(res_timeout), 32'(m_to));
            chk("cyc_spurious", 32'(spurious_err), 32'(m_spur));
        end
    end

    task automatic run_op(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [1:0] rc, input logic [31:0] rd, input int dly,
                          input string tag);
        int n;
        n = 0;
        while (!op_rdy && n < 20) begin @(negedge c_clk); n++; end
        chk({tag, "_op_rdy"}, 32'(op_rdy), 32'd1);
        op_vld = 1; op_cmd = cmd; op_data1 = d1; op_data2 = d2;
        @(negedge c_clk);
        op_vld = 0;
        repeat (1 + dly) @(negedge c_clk);
        resp_in = rc; resp_data_in = rd;
        @(negedge c_clk);
        resp_in = 0; resp_data_in = 0;
        n = 0;
        while (!res_vld && n < 20) begin @(negedge c_clk); n++; end
        chk({tag, "_vld"}, 32'(res_vld), 32'd1);
        chk({tag, "_resp"}, 32'(res_resp), 32'(rc));
        chk({tag, "_data"}, res_data, rd);
        chk({tag, "_timeout"}, 32'(res_timeout), 32'd0);
        if (!res_rdy) begin
            res_rdy = 1;
            @(negedge c_clk);
            res_rdy = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1; op_vld = 0; op_cmd = 0; op_data1 = 0; op_data2 = 0;
        resp_in = 0; resp_data_in = 0; res_rdy = 0;
        #1 reset = 0;
        repeat (2) @(negedge c_clk);
        chk("rst_req_cmd", 32'(req_cmd_out), 32'd0);
        chk("rst_req_data", req_data_out, 32'd0);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_spurious", 32'(spurious_err), 32'd0);
        cmp_en = 1;
        reset = 1;
        @(negedge c_clk);
        chk("rst_op_rdy", 32'(op_rdy), 32'd1);

        // ADD 5+3, response in cycle N+5.
        op_vld = 1; op_cmd = CMD_ADD; op_data1 = 32'h5; op_data2 = 32'h3;
        @(negedge c_clk);
        op_vld = 0;
        chk("add_beat1_cmd", 32'(req_cmd_out), 32'd1);
        chk("add_beat1_data", req_data_out, 32'h5);
        chk("add_busy", 32'(op_rdy), 32'd0);
        @(negedge c_clk);
        chk("add_beat2_cmd", 32'(req_cmd_out), 32'd0);
        chk("add_beat2_data", req_data_out, 32'h3);
        repeat (3) @(negedge c_clk);
        chk("add_no_res_yet", 32'(res_vld), 32'd0);
        resp_in = RESP_OK; resp_data_in = 32'h8;
        @(negedge c_clk);
        resp_in = 0; resp_data_in = 0;
        chk("add_res_vld", 32'(res_vld), 32'd1);
        chk("add_res_resp", 32'(res_resp), 32'd1);
        chk("add_res_data", res_data, 32'h8);
        chk("add_res_timeout", 32'(res_timeout), 32'd0);
        res_rdy = 1;
        @(negedge c_clk);
        res_rdy = 0;
        chk("add_release_rdy", 32'(op_rdy), 32'd1);
        chk("add_release_vld", 32'(res_vld), 32'd0);

        // No response: timeout after TMO WAIT cycles, then a late response.
        op_vld = 1; op_cmd = CMD_NOP; op_data1 = 32'h11; op_data2 = 32'h22;
        @(negedge c_clk);
        op_vld = 0;
        repeat (4) @(negedge c_clk);
        chk("tmo_not_yet", 32'(res_vld), 32'd0);
        @(negedge c_clk);
        chk("tmo_vld", 32'(res_vld), 32'd1);
        chk("tmo_flag", 32'(res_timeout), 32'd1);
        chk("tmo_resp", 32'(res_resp), 32'd0);
        chk("tmo_data", res_data, 32'd0);
        resp_in = RESP_OK; resp_data_in = 32'hDEADBEEF;
        @(negedge c_clk);
        resp_in = 0; resp_data_in = 0;
        chk("late_spurious", 32'(spurious_err), 32'd1);
        chk("late_keep_data", res_data, 32'd0);
        chk("late_keep_resp", 32'(res_resp), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge c_clk);
            chk("hold_vld", 32'(res_vld), 32'd1);
            chk("hold_timeout", 32'(res_timeout), 32'd1);
            chk("hold_op_rdy", 32'(op_rdy), 32'd0);
        end
        res_rdy = 1;
        @(negedge c_clk);
        res_rdy = 0;
        chk("hold_release_rdy", 32'(op_rdy), 32'd1);

        // Reset clears the sticky flag; a response while idle sets it again.
        #2 reset = 0;
        #1 chk("rst_clears_spur", 32'(spurious_err), 32'd0);
        @(negedge c_clk);
        reset = 1;
        resp_in = RESP_OVFL;
        @(negedge c_clk);
        resp_in = 0;
        chk("idle_spurious", 32'(spurious_err), 32'd1);
        run_op(CMD_ADD, 32'h7, 32'h9, RESP_OK, 32'h10, 0, "sticky_add");
        chk("sticky_kept", 32'(spurious_err), 32'd1);

        // Reset during WAIT: outputs clear without a clock edge.
        op_vld = 1; op_cmd = CMD_ADD; op_data1 = 32'hA; op_data2 = 32'hB;
        @(negedge c_clk);
        op_vld = 0;
        @(negedge c_clk);
        #2 reset = 0;
        #1;
        chk("midrst_req_cmd", 32'(req_cmd_out), 32'd0);
        chk("midrst_req_data", req_data_out, 32'd0);
        chk("midrst_res_vld", 32'(res_vld), 32'd0);
        chk("midrst_spurious", 32'(spurious_err), 32'd0);
        chk("midrst_op_rdy", 32'(op_rdy), 32'd1);
        @(negedge c_clk);
        reset = 1;
        run_op(CMD_ADD, 32'h2, 32'h2, RESP_OK, 32'h4, 1, "post_rst_add");

        // Back-to-back with the result consumed immediately.
        res_rdy = 1;
        run_op(CMD_SUB, 32'h10, 32'h1, RESP_OK, 32'hF, 1, "b2b_sub");
        run_op(CMD_SHL, 32'h1, 32'h4, RESP_OK, 32'h10, 2, "b2b_shl");
        run_op(CMD_SHR, 32'h100, 32'h4, RESP_INVAL, 32'h0, 0, "b2b_shr");
        @(negedge c_clk);
        res_rdy = 0;
        repeat (2) @(negedge c_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
